// File: rtl/sbqm_queue_ctrl_if.sv
// Signal bundle between the bank door photocells / teller setting and the
// queue controller, plus the pulses and status it returns.
interface sbqm_queue_ctrl_if;
  logic       back_sensor;
  logic       front_sensor;
  logic [1:0] tcount;
  logic       up;
  logic       down;
  logic       reject;
  logic [2:0] pcount;
  logic       full;
  logic       empty;
  logic [4:0] wtime;

  modport master (
    output back_sensor, front_sensor, tcount,
    input  up, down, reject, pcount, full, empty, wtime
  );

  modport slave (
    input  back_sensor, front_sensor, tcount,
    output up, down, reject, pcount, full, empty, wtime
  );
endinterface

// File: rtl/sbqm_queue_ctrl.sv
// Bank queue controller: debounces the entry/exit photocells, turns completed
// pass-throughs into up/down pulses and tracks occupancy and wait estimate.
module sbqm_queue_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SVC_TIME        = 3
) (
  input  logic               clk,
  input  logic               rst,
  sbqm_queue_ctrl_if.slave   sb
);

  typedef enum logic [1:0] {IDLE, QUAL_HI, BLOCKED, QUAL_LO} deb_state_t;

  localparam logic [3:0] DMAX = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] SVC8 = 8'(SVC_TIME);

  // Index 0 is the entry (back) path, index 1 the exit (front) path.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] evt;
  deb_state_t st  [2];
  logic [3:0] cnt [2];

  logic       up_q;
  logic       down_q;
  logic       reject_q;
  logic [2:0] pcount_q;
  logic [4:0] wtime_q;
  logic [2:0] pnext;
  logic [4:0] wnext;
  logic [7:0] p8;
  logic [7:0] prod1;
  logic [7:0] prod2;
  logic [7:0] prod3;
  logic       e;
  logic       x;

  // The sample that causes a qualifying transition already counts as the
  // first of the DEBOUNCE_CYCLES stable samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      evt   <= '0;
      for (int i = 0; i < 2; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= {sb.front_sensor, sb.back_sensor};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        evt[i] <= 1'b0;
        case (st[i])
          IDLE: begin
            if (sync2[i]) begin
              if (DMAX == 4'd0) begin
                st[i] <= BLOCKED;
              end else begin
                st[i]  <= QUAL_HI;
                cnt[i] <= 4'd1;
              end
            end
          end
          QUAL_HI: begin
            if (!sync2[i]) begin
              st[i]  <= IDLE;
              cnt[i] <= '0;
            end else if (cnt[i] >= DMAX) begin
              st[i]  <= BLOCKED;
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + 4'd1;
            end
          end
          BLOCKED: begin
            if (!sync2[i]) begin
              if (DMAX == 4'd0) begin
                st[i]  <= IDLE;
                evt[i] <= 1'b1;
              end else begin
                st[i]  <= QUAL_LO;
                cnt[i] <= 4'd1;
              end
            end
          end
          QUAL_LO: begin
            if (sync2[i]) begin
              st[i]  <= BLOCKED;
              cnt[i] <= '0;
            end else if (cnt[i] >= DMAX) begin
              st[i]  <= IDLE;
              cnt[i] <= '0;
              evt[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 4'd1;
            end
          end
          default: begin
            st[i]  <= IDLE;
            cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  assign e = evt[0];
  assign x = evt[1];

  // Arbitration looks at the count including any pulse still in flight, so
  // an exit right behind an entry is not wrongly rejected.
  always_comb begin
    pnext = pcount_q;
    if (up_q && !down_q && pcount_q != 3'd7) begin
      pnext = pcount_q + 3'd1;
    end else if (down_q && !up_q && pcount_q != 3'd0) begin
      pnext = pcount_q - 3'd1;
    end
  end

  always_comb begin
    p8    = {5'd0, pcount_q};
    prod1 = SVC8 * p8;
    prod2 = SVC8 * (p8 + 8'd1);
    prod3 = SVC8 * (p8 + 8'd2);
    wnext = '0;
    if (pcount_q != 3'd0) begin
      case (sb.tcount)
        2'd2:    wnext = 5'(prod2 / 8'd2);
        2'd3:    wnext = 5'(prod3 / 8'd3);
        default: wnext = 5'(prod1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      reject_q <= 1'b0;
      pcount_q <= '0;
      wtime_q  <= '0;
    end else begin
      pcount_q <= pnext;
      up_q     <= e && !x && (pnext != 3'd7);
      down_q   <= x && !e && (pnext != 3'd0);
      reject_q <= (e && !x && (pnext == 3'd7)) || (x && !e && (pnext == 3'd0));
      wtime_q  <= wnext;
    end
  end

  assign sb.up     = up_q;
  assign sb.down   = down_q;
  assign sb.reject = reject_q;
  assign sb.pcount = pcount_q;
  assign sb.full   = (pcount_q == 3'd7);
  assign sb.empty  = (pcount_q == 3'd0);
  assign sb.wtime  = wtime_q;

endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// Directed bench for sbqm_queue_ctrl: a timed vector table for the exact
// pulse latencies, then multi-cycle sequences for the occupancy corners.
module tb_sbqm_queue_ctrl;

  logic clk;
  logic rst;
  int   cmpCount;
  int   failCount;

  sbqm_queue_ctrl_if sbif ();

  sbqm_queue_ctrl #(.DEBOUNCE_CYCLES(4), .SVC_TIME(3)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic       f;
    logic [1:0] tc;
    int         cycles;
    logic       up;
    logic       down;
    logic       rej;
    logic [2:0] p;
    logic       full;
    logic       empty;
    logic [4:0] w;
  } vec_t;

  vec_t vecs [18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic checkAll(input string nm, input vec_t v);
    checkOutput({nm, ".up"},     32'(sbif.up),     32'(v.up));
    checkOutput({nm, ".down"},   32'(sbif.down),   32'(v.down));
    checkOutput({nm, ".reject"}, 32'(sbif.reject), 32'(v.rej));
    checkOutput({nm, ".pcount"}, 32'(sbif.pcount), 32'(v.p));
    checkOutput({nm, ".full"},   32'(sbif.full),   32'(v.full));
    checkOutput({nm, ".empty"},  32'(sbif.empty),  32'(v.empty));
    checkOutput({nm, ".wtime"},  32'(sbif.wtime),  32'(v.w));
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    sbif.back_sensor  = v.b;
    sbif.front_sensor = v.f;
    sbif.tcount       = v.tc;
    repeat (v.cycles) tick();
    checkAll($sformatf("vec%0d", idx), v);
  endtask

  // Block the selected beams, release them together, and count every pulse
  // seen over the whole pass.
  task automatic doPass(input logic b, input logic f, input int expUp, input int expDown,
                        input int expRej, input int expP, input string nm);
    int nUp;
    int nDown;
    int nRej;
    int nBoth;
    nUp = 0; nDown = 0; nRej = 0; nBoth = 0;
    sbif.back_sensor  = b;
    sbif.front_sensor = f;
    for (int i = 0; i < 24; i++) begin
      if (i == 10) begin
        sbif.back_sensor  = 1'b0;
        sbif.front_sensor = 1'b0;
      end
      tick();
      if (sbif.up)                nUp++;
      if (sbif.down)              nDown++;
      if (sbif.reject)            nRej++;
      if (sbif.up && sbif.down)   nBoth++;
    end
    checkOutput({nm, ".upPulses"},     32'(nUp),         32'(expUp));
    checkOutput({nm, ".downPulses"},   32'(nDown),       32'(expDown));
    checkOutput({nm, ".rejectPulses"}, 32'(nRej),        32'(expRej));
    checkOutput({nm, ".upAndDown"},    32'(nBoth),       32'd0);
    checkOutput({nm, ".pcount"},       32'(sbif.pcount), 32'(expP));
  endtask

  initial begin
    cmpCount  = 0;
    failCount = 0;

    //          b     f     tc    cyc  up    dn    rj    p     full  empty w
    vecs[0]  = '{1'b1, 1'b0, 2'd1, 10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd0};
    vecs[1]  = '{1'b0, 1'b0, 2'd1,  6, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd0};
    vecs[2]  = '{1'b0, 1'b0, 2'd1,  1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd0};
    vecs[3]  = '{1'b0, 1'b0, 2'd1,  1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd0};
    vecs[4]  = '{1'b0, 1'b0, 2'd1,  1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd3};
    vecs[5]  = '{1'b1, 1'b0, 2'd1,  3, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd3};
    vecs[6]  = '{1'b0, 1'b0, 2'd1, 12, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd3};
    vecs[7]  = '{1'b1, 1'b0, 2'd1,  8, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd3};
    vecs[8]  = '{1'b0, 1'b0, 2'd1,  3, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd3};
    vecs[9]  = '{1'b1, 1'b0, 2'd1,  9, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd3};
    vecs[10] = '{1'b0, 1'b0, 2'd1,  6, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd3};
    vecs[11] = '{1'b0, 1'b0, 2'd1,  1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd3};
    vecs[12] = '{1'b0, 1'b0, 2'd1,  1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 5'd3};
    vecs[13] = '{1'b0, 1'b0, 2'd1,  1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 5'd6};
    vecs[14] = '{1'b0, 1'b1, 2'd1, 10, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 5'd6};
    vecs[15] = '{1'b0, 1'b0, 2'd1,  7, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 5'd6};
    vecs[16] = '{1'b0, 1'b0, 2'd1,  1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd6};
    vecs[17] = '{1'b0, 1'b0, 2'd1,  1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 5'd3};

    rst               = 1'b1;
    sbif.back_sensor  = 1'b0;
    sbif.front_sensor = 1'b0;
    sbif.tcount       = 2'd1;
    repeat (3) tick();
    checkAll("reset", '{1'b0, 1'b0, 2'd1, 0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd0});
    rst = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      applyStimulus(i, vecs[i]);
    end

    doPass(1'b0, 1'b1, 0, 1, 0, 0, "exitLast");
    doPass(1'b0, 1'b1, 0, 0, 1, 0, "exitEmpty");
    checkOutput("exitEmpty.wtime", 32'(sbif.wtime), 32'd0);
    doPass(1'b1, 1'b0, 1, 0, 0, 1, "entry1");
    doPass(1'b1, 1'b0, 1, 0, 0, 2, "entry2");
    doPass(1'b1, 1'b0, 1, 0, 0, 3, "entry3");
    doPass(1'b1, 1'b1, 0, 0, 0, 3, "bothAt3");
    doPass(1'b1, 1'b0, 1, 0, 0, 4, "entry4");

    checkOutput("p4t1.wtime", 32'(sbif.wtime), 32'd12);
    sbif.tcount = 2'd2;
    tick();
    checkOutput("p4t2.wtime", 32'(sbif.wtime), 32'd7);
    sbif.tcount = 2'd3;
    tick();
    checkOutput("p4t3.wtime", 32'(sbif.wtime), 32'd6);
    sbif.tcount = 2'd0;
    checkOutput("p4t0.wtimeBeforeEdge", 32'(sbif.wtime), 32'd6);
    tick();
    checkOutput("p4t0.wtime", 32'(sbif.wtime), 32'd12);
    checkOutput("p4t0.pcount", 32'(sbif.pcount), 32'd4);
    sbif.tcount = 2'd1;

    doPass(1'b1, 1'b0, 1, 0, 0, 5, "entry5");
    doPass(1'b1, 1'b0, 1, 0, 0, 6, "entry6");
    doPass(1'b1, 1'b0, 1, 0, 0, 7, "entry7");
    checkOutput("at7.full",  32'(sbif.full),  32'd1);
    checkOutput("at7.wtime", 32'(sbif.wtime), 32'd21);
    doPass(1'b1, 1'b0, 0, 0, 1, 7, "entryFull");
    checkOutput("entryFull.full",  32'(sbif.full),  32'd1);
    checkOutput("entryFull.wtime", 32'(sbif.wtime), 32'd21);

    // Reset lands while an entry event is in flight; the beam stays blocked
    // through reset release and must be requalified before it counts.
    sbif.back_sensor = 1'b1;
    repeat (8) tick();
    sbif.back_sensor = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    sbif.back_sensor = 1'b1;
    tick();
    checkAll("midReset", '{1'b0, 1'b0, 2'd1, 0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd0});
    tick();
    rst = 1'b0;
    doPass(1'b1, 1'b0, 1, 0, 0, 1, "heldThroughReset");
    checkOutput("heldThroughReset.wtime", 32'(sbif.wtime), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
